id_exe_skid_reg: RTL and testbench
==================================

Name: id_exe_skid_reg

Overview:
Parametrised successor to the ID→EXE stage register. Carries decoded control and operand fields from decode to execute behind a valid/ready handshake. A 2-entry skid buffer lets execute back-pressure without a combinational ready path into decode. Adds a working synchronous flush that squashes in-flight entries on a branch, and a saturating downstream-stall counter.

Parameters:
DATA_W, 32, width of pc, val_rn, val_rm
CMD_W, 4, width of exe_cmd
REG_W, 4, width of dest
SHOP_W, 12, width of shift_operand
IMM_W, 24, width of signed_imm
SR_W, 4, width of status flags (NZCV)
CNT_W, 16, width of stall counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous squash of all held entries
in_valid  in  1  decode presents an entry
in_ready  out  1  stage can accept; registered
in_ctrl  in  5  {wb_en, mem_r_en, mem_w_en, b, s}
in_exe_cmd  in  CMD_W  ALU command
in_pc  in  DATA_W  PC of instruction
in_val_rn  in  DATA_W  operand Rn
in_val_rm  in  DATA_W  operand Rm
in_imm  in  1  immediate flag
in_shift_operand  in  SHOP_W  shifter operand
in_signed_imm  in  IMM_W  branch offset
in_dest  in  REG_W  destination register
in_sr  in  SR_W  status flags
out_valid  out  1  entry presented to execute
out_ready  in  1  execute accepts
out_ctrl, out_exe_cmd, out_pc, out_val_rn, out_val_rm, out_imm, out_shift_operand, out_signed_imm, out_dest, out_sr  out  (widths as in_*)  head entry fields
occupancy  out  2  entries held (0..2)
stall_cnt  out  CNT_W  saturating count of out_valid & ~out_ready cycles

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives outputs) and skid register, each with its own payload; FSM state EMPTY / ONE / TWO.
- Reset (async, rst=1): state EMPTY, every payload field and every output 0, except in_ready=1. stall_cnt=0. Reset mid-transfer discards all entries.
- in_ready = (next state != TWO), registered; never depends combinationally on out_ready.
- out_valid = (state != EMPTY), driven from the state register.
- Transitions (flush=0):
  - EMPTY: in_fire → ONE, main ← in.
  - ONE: in_fire & out_fire → ONE, main ← in. in_fire & ~out_fire → TWO, skid ← in. ~in_fire & out_fire → EMPTY. Otherwise hold.
  - TWO: in_ready=0. out_fire → ONE, main ← skid. Otherwise hold.
- Order is strictly FIFO; latency in→out is 1 cycle when empty or when draining at rate. Throughput is 1 entry/cycle with out_ready held high.
- Flush (priority over everything except rst): next state EMPTY; ctrl fields of main and skid cleared to 0; any in_fire that cycle is discarded; in_ready=1 next cycle. The out_fire in the flush cycle still completes, because execute sampled it.
- Bubble masking: while out_valid=0, out_ctrl is forced 0. Other out_* fields hold their last value and are don't-care.
- occupancy = 0/1/2 for EMPTY/ONE/TWO.
- stall_cnt: increments each cycle out_valid & ~out_ready; saturates at all-ones; cleared only by rst. Unaffected by flush.
- No X propagation: payload registers load only on the defined transitions.

Test Plan:
- Streaming: out_ready=1, 8 back-to-back entries with pc=0x00,0x04..0x1C → each appears on out_pc one cycle after in_fire, in order, occupancy ≤1, stall_cnt=0.
- Back-pressure: out_ready=0, push pc=0x100, 0x104 → occupancy=2, in_ready=0 next cycle. Third entry 0x108 held by decode. Release out_ready → outputs 0x100, 0x104, 0x108 in order. stall_cnt equals the number of cycles out_ready was low with out_valid=1.
- Flush with TWO entries (ctrl=5'b11111) plus simultaneous in_valid → next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1. The flushed-cycle input never appears at the output.
- Async reset asserted mid-stream between clock edges → all outputs 0 and in_ready=1 immediately, without waiting for clk. After release, the first entry passes with 1-cycle latency.
- Saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt stops at 15.
- Simultaneous in_fire & out_fire in state ONE → occupancy stays 1 and out_pc shows the new entry next cycle.

Source files
------------

// File: rtl/id_exe_skid_reg.sv
// ID->EXE stage register with a 2-entry skid buffer, synchronous flush and a
// saturating downstream-stall counter. in_ready is registered so execute's ready never reaches decode combinationally.
module id_exe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 4,
  parameter int REG_W  = 4,
  parameter int SHOP_W = 12,
  parameter int IMM_W  = 24,
  parameter int SR_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_ctrl,
  input  logic [CMD_W-1:0]  in_exe_cmd,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_val_rn,
  input  logic [DATA_W-1:0] in_val_rm,
  input  logic              in_imm,
  input  logic [SHOP_W-1:0] in_shift_operand,
  input  logic [IMM_W-1:0]  in_signed_imm,
  input  logic [REG_W-1:0]  in_dest,
  input  logic [SR_W-1:0]   in_sr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_ctrl,
  output logic [CMD_W-1:0]  out_exe_cmd,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_val_rn,
  output logic [DATA_W-1:0] out_val_rm,
  output logic              out_imm,
  output logic [SHOP_W-1:0] out_shift_operand,
  output logic [IMM_W-1:0]  out_signed_imm,
  output logic [REG_W-1:0]  out_dest,
  output logic [SR_W-1:0]   out_sr,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [4:0]        ctrl;
    logic [CMD_W-1:0]  exe_cmd;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic              imm;
    logic [SHOP_W-1:0] shop;
    logic [IMM_W-1:0]  simm;
    logic [REG_W-1:0]  dest;
    logic [SR_W-1:0]   sr;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  entry_t           main_q, main_d, skid_q, skid_d, in_ent;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             in_fire, out_fire;

  assign in_ent = '{ctrl: in_ctrl, exe_cmd: in_exe_cmd, pc: in_pc, val_rn: in_val_rn,
                    val_rm: in_val_rm, imm: in_imm, shop: in_shift_operand,
                    simm: in_signed_imm, dest: in_dest, sr: in_sr};

  assign out_valid = (state_q != S_EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      // Squash: the head's out_fire this cycle still counts, nothing new is taken.
      state_d     = S_EMPTY;
      main_d.ctrl = '0;
      skid_d.ctrl = '0;
    end else begin
      case (state_q)
        S_EMPTY: if (in_fire) begin
          state_d = S_ONE;
          main_d  = in_ent;
        end
        S_ONE: begin
          if (in_fire && out_fire) main_d = in_ent;
          else if (in_fire) begin
            state_d = S_TWO;
            skid_d  = in_ent;
          end else if (out_fire) state_d = S_EMPTY;
        end
        S_TWO: if (out_fire) begin
          state_d = S_ONE;
          main_d  = skid_q;
        end
        default: state_d = S_EMPTY;
      endcase
    end
    in_ready_d = (state_d != S_TWO);
    if (out_valid && !out_ready && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign out_ctrl          = out_valid ? main_q.ctrl : 5'b0;
  assign out_exe_cmd       = main_q.exe_cmd;
  assign out_pc            = main_q.pc;
  assign out_val_rn        = main_q.val_rn;
  assign out_val_rm        = main_q.val_rm;
  assign out_imm           = main_q.imm;
  assign out_shift_operand = main_q.shop;
  assign out_signed_imm    = main_q.simm;
  assign out_dest          = main_q.dest;
  assign out_sr            = main_q.sr;
  assign occupancy         = {state_q == S_TWO, state_q == S_ONE};
  assign stall_cnt         = stall_cnt_q;

endmodule

// File: tb/tb_id_exe_skid_reg.sv
// Bench for id_exe_skid_reg: a FIFO-queue model checked every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_id_exe_skid_reg;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, in_imm, out_imm;
  logic [4:0]  in_ctrl, out_ctrl;
  logic [3:0]  in_exe_cmd, out_exe_cmd, in_dest, out_dest, in_sr, out_sr;
  logic [31:0] in_pc, out_pc, in_val_rn, out_val_rn, in_val_rm, out_val_rm;
  logic [11:0] in_shift_operand, out_shift_operand;
  logic [23:0] in_signed_imm, out_signed_imm;
  logic [1:0]  occupancy;
  logic [CW-1:0] stall_cnt;

  id_exe_skid_reg #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_exe_cmd(in_exe_cmd), .in_pc(in_pc), .in_val_rn(in_val_rn),
    .in_val_rm(in_val_rm), .in_imm(in_imm), .in_shift_operand(in_shift_operand),
    .in_signed_imm(in_signed_imm), .in_dest(in_dest), .in_sr(in_sr),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_exe_cmd(out_exe_cmd), .out_pc(out_pc), .out_val_rn(out_val_rn),
    .out_val_rm(out_val_rm), .out_imm(out_imm), .out_shift_operand(out_shift_operand),
    .out_signed_imm(out_signed_imm), .out_dest(out_dest), .out_sr(out_sr),
    .occupancy(occupancy), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ctrl;
    logic [3:0]  cmd, dest, sr;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] shop;
    logic [23:0] simm;
  } ent_t;

  ent_t mq[$];
  bit   mrdy = 1'b1;
  int   mcnt = 0;
  bit   last_fire = 1'b0;
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t cur_in();
    ent_t e;
    e.ctrl = in_ctrl; e.cmd = in_exe_cmd; e.dest = in_dest; e.sr = in_sr;
    e.pc = in_pc; e.rn = in_val_rn; e.rm = in_val_rm; e.imm = in_imm;
    e.shop = in_shift_operand; e.simm = in_signed_imm;
    return e;
  endfunction

  task automatic set_in(input logic [31:0] pc, input logic [4:0] ctrl);
    in_pc = pc; in_ctrl = ctrl;
    in_exe_cmd = 4'($urandom); in_dest = 4'($urandom); in_sr = 4'($urandom);
    in_val_rn = $urandom; in_val_rm = $urandom; in_imm = 1'($urandom);
    in_shift_operand = 12'($urandom); in_signed_imm = 24'($urandom);
  endtask

  // Reference: a queue of at most two entries, FIFO order, flush empties it.
  initial begin
    bit ov, ofire, ifire;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete(); mrdy = 1'b1; mcnt = 0; last_fire = 1'b0;
      end else begin
        ov    = mq.size() > 0;
        ofire = ov && out_ready;
        ifire = in_valid && mrdy;
        if (ov && !out_ready && mcnt < (1 << CW) - 1) mcnt++;
        if (ofire) void'(mq.pop_front());
        if (flush) mq.delete();
        else if (ifire) mq.push_back(cur_in());
        mrdy = mq.size() < 2;
        last_fire = ifire;
      end
    end
  end

  // Compare process: every outputs is registered, so negedge sampling is race-free.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("out_valid", out_valid, mq.size() > 0);
        chk("in_ready", in_ready, mrdy);
        chk("occupancy", occupancy, mq.size());
        chk("stall_cnt", stall_cnt, mcnt);
        if (mq.size() > 0) begin
          chk("out_ctrl", out_ctrl, mq[0].ctrl);
          chk("out_pc", out_pc, mq[0].pc);
          chk("out_rn", out_val_rn, mq[0].rn);
          chk("out_rm", out_val_rm, mq[0].rm);
          chk("out_misc", {out_exe_cmd, out_dest, out_sr, out_imm, out_shift_operand, out_signed_imm},
              {mq[0].cmd, mq[0].dest, mq[0].sr, mq[0].imm, mq[0].shop, mq[0].simm});
        end else chk("bubble_ctrl", out_ctrl, 5'b0);
      end
    end
  end

  task automatic cyc();
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_in(32'h0, 5'h0);
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_occ", occupancy, 2'd0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_stall", stall_cnt, 4'd0);
    @(negedge clk); rst = 1'b0; #1;

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; set_in(32'(i * 4), 5'($urandom));
      cyc();
      chk("stream_pc", out_pc, 32'(i * 4));
      chk("stream_occ", occupancy, 2'd1);
      chk("stream_stall", stall_cnt, 4'd0);
    end
    in_valid = 1'b0;
    cyc(); chk("stream_drain", occupancy, 2'd0);

    // Back-pressure into the skid slot
    out_ready = 1'b0; in_valid = 1'b1; set_in(32'h100, 5'h3);
    cyc(); chk("bp_occ1", occupancy, 2'd1);
    set_in(32'h104, 5'h5);
    cyc(); chk("bp_occ2", occupancy, 2'd2); chk("bp_rdy", in_ready, 1'b0);
    set_in(32'h108, 5'h9);
    cyc(); cyc();
    chk("bp_hold_pc", out_pc, 32'h100); chk("bp_stall", stall_cnt, 4'd3);
    out_ready = 1'b1;
    cyc(); chk("bp_pc1", out_pc, 32'h104); chk("bp_occ_rel", occupancy, 2'd1);
    cyc(); chk("bp_pc2", out_pc, 32'h108);
    in_valid = 1'b0;
    cyc(); chk("bp_empty", out_valid, 1'b0); chk("bp_stall_keep", stall_cnt, 4'd3);

    // Flush while full, with decode presenting a new entry
    out_ready = 1'b0; in_valid = 1'b1; set_in(32'h200, 5'b11111);
    cyc(); set_in(32'h204, 5'b11111);
    cyc(); chk("fl_full", occupancy, 2'd2);
    flush = 1'b1; set_in(32'h300, 5'b10101);
    cyc(); flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 1'b0); chk("fl_ctrl", out_ctrl, 5'b0);
    chk("fl_occ", occupancy, 2'd0); chk("fl_rdy", in_ready, 1'b1);
    cyc(); chk("fl_no_ghost", out_valid, 1'b0);

    // Async reset between clock edges
    in_valid = 1'b1; set_in(32'h400, 5'h1f);
    cyc(); in_valid = 1'b0;
    #1 rst = 1'b1; #1;
    chk("ar_valid", out_valid, 1'b0); chk("ar_rdy", in_ready, 1'b1);
    chk("ar_occ", occupancy, 2'd0); chk("ar_pc", out_pc, 32'h0); chk("ar_stall", stall_cnt, 4'd0);
    #1 rst = 1'b0;
    cyc(); out_ready = 1'b1; in_valid = 1'b1; set_in(32'h500, 5'h11);
    cyc(); in_valid = 1'b0;
    chk("ar_first_pc", out_pc, 32'h500); chk("ar_first_v", out_valid, 1'b1);
    cyc();

    // Stall counter saturation
    out_ready = 1'b0; in_valid = 1'b1; set_in(32'h600, 5'h2);
    cyc(); in_valid = 1'b0;
    repeat (20) cyc();
    chk("sat_stall", stall_cnt, 4'd15);
    out_ready = 1'b1; cyc();

    // Randomized traffic with flushes and back-pressure
    in_valid = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); #2;
      flush = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (!in_valid || last_fire) begin
        in_valid = ($urandom_range(0, 3) != 0);
        set_in($urandom, 5'($urandom));
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
